// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one result bit per cycle, fixed WIDTH+2 cycle latency
// from the start cycle to done, with start/busy/done handshake and flush abort.
module muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             div0_q, div0_d;

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic signed_op);
        return (signed_op && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Multiply: accumulator {acc_hi, acc_lo} with the multiplier in acc_lo, shifted right each step.
    // Divide: acc_hi is the remainder, acc_lo the dividend/quotient shift register.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_fits;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_fits  = (div_shift >= {1'b0, opnd_q});
    // When the divisor fits, the true difference is below the divisor, so WIDTH bits suffice.
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    assign prod_fix  = neg2_if({acc_hi_q, acc_lo_q}, neg_res_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        busy_d    = busy_q;
        done_d    = done_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        div0_d    = div0_q;

        if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_d = 1'b0;
                    if (start) begin
                        state_d   = S_CALC;
                        busy_d    = 1'b1;
                        cnt_d     = CW'(WIDTH - 1);
                        is_div_d  = op[1];
                        opnd_d    = op[1] ? abs_w(b, op[0]) : abs_w(a, op[0]);
                        acc_lo_d  = op[1] ? abs_w(a, op[0]) : abs_w(b, op[0]);
                        acc_hi_d  = '0;
                        neg_res_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_d = op[0] & a[WIDTH-1];
                        dz_d      = op[1] & (b == '0);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (is_div_q) begin
                        acc_hi_d = div_fits ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], div_fits};
                    end else begin
                        acc_hi_d = mul_sum[WIDTH:1];
                        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    end
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    div0_d  = dz_q;
                    if (is_div_q) begin
                        // Divide by zero naturally leaves |a| as remainder; the quotient is forced.
                        res_lo_d = dz_q ? '1 : neg_if(acc_lo_q, neg_res_q);
                        res_hi_d = neg_if(acc_hi_q, neg_rem_q);
                    end else begin
                        res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        res_lo_d = prod_fix[WIDTH-1:0];
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            div0_q    <= div0_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, abort/reissue cases and
// randomized operations checked against an arithmetic reference model.
module tb_muldiv_unit;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result_hi;
    logic [W-1:0] result_lo;
    logic         div0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result_hi (result_hi),
        .result_lo (result_lo),
        .div0      (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        logic signed [W-1:0] xs;
        logic signed [W-1:0] ys;
        longint sx, sy, ux, uy;
        logic [63:0] p, q, r;
        xs = x; ys = y;
        sx = xs; sy = ys;
        ux = longint'(x); uy = longint'(y);
        dz = 1'b0;
        case (o)
            2'b00: begin p = ux * uy; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            2'b01: begin p = sx * sy; hi = p[2*W-1:W]; lo = p[W-1:0]; end
            default: begin
                if (y == '0) begin
                    dz = 1'b1; lo = '1; hi = x;
                end else if (o == 2'b10) begin
                    q = ux / uy; r = ux % uy; lo = q[W-1:0]; hi = r[W-1:0];
                end else if (sx == -(longint'(1) <<< (W - 1)) && sy == -1) begin
                    lo = x; hi = '0;
                end else begin
                    q = sx / sy; r = sx % sy; lo = q[W-1:0]; hi = r[W-1:0];
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit second_start);
        int cyc;
        int nbusy;
        logic [W-1:0] mh, ml;
        logic mz;
        model(o, x, y, mh, ml, mz);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("done_drop", done, 0);
        cyc = 0;
        nbusy = 0;
        while (done !== 1'b1 && cyc < 3 * W) begin
            if (busy === 1'b1) nbusy++;
            if (second_start && cyc == 4) begin
                op = ~o; a = ~x; b = y ^ 16'h5a5a; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk("latency", cyc + 1, W + 2);
        chk("busy_cycles", nbusy, W + 1);
        chk("busy_at_done", busy, 0);
        chk("result_hi", result_hi, mh);
        chk("result_lo", result_lo, ml);
        chk("div0", div0, mz);
        exp_hi = mh; exp_lo = ml; exp_dz = mz;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("done_pulse", done, 0);
            chk("hold_hi", result_hi, exp_hi);
            chk("hold_lo", result_lo, exp_lo);
        end
    endtask

    task automatic dir_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
        run_op(o, x, y, 0);
        chk("dir_hi", result_hi, hi);
        chk("dir_lo", result_lo, lo);
        chk("dir_div0", div0, dz);
        idle(1);
    endtask

    task automatic abort_op(input bit use_rst);
        int seen;
        op = 2'b10; a = W'($urandom); b = W'($urandom) | W'(1); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0;
        if (use_rst) begin exp_hi = '0; exp_lo = '0; exp_dz = 1'b0; end
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", result_hi, exp_hi);
        chk("abort_lo", result_lo, exp_lo);
        chk("abort_div0", div0, exp_dz);
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("abort_no_done", seen, 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return W'(1);
            4: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", result_hi, 0);
        chk("rst_lo", result_lo, 0);
        chk("rst_div0", div0, 0);
        rst = 1'b0;
        idle(2);

        dir_op(2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
        dir_op(2'b01, 16'hFFFD, 16'h0007, 16'hFFFF, 16'hFFEB, 1'b0);
        dir_op(2'b01, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0);
        dir_op(2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0);
        dir_op(2'b10, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0);
        dir_op(2'b10, 16'd100,  16'd0,    16'h0064, 16'hFFFF, 1'b1);
        dir_op(2'b00, 16'd2,    16'd3,    16'h0000, 16'h0006, 1'b0);
        dir_op(2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
        dir_op(2'b11, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1);

        run_op(2'b10, 16'd1234, 16'd10, 1);
        chk("ignored_start_lo", result_lo, 16'd123);
        chk("ignored_start_hi", result_hi, 16'd4);
        idle(1);

        abort_op(1'b0);
        abort_op(1'b1);

        run_op(2'b01, 16'hFFFD, 16'h0007, 0);
        run_op(2'b11, 16'hFFF9, 16'h0002, 0);
        run_op(2'b10, 16'd100, 16'd0, 0);
        idle(1);

        for (int i = 0; i < 150; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 0);
            if ($urandom_range(0, 1) == 1) idle(1 + $urandom_range(0, 1));
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
